// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter; PS2_TX_TIMEOUT_EN adds a SEND/ACK watchdog
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 100,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETUP_CYCLES - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] INHIBIT = 3'd1;
    localparam logic [2:0] START   = 3'd2;
    localparam logic [2:0] SEND    = 3'd3;
    localparam logic [2:0] ACK     = 3'd4;

    if (INHIBIT_CYCLES < 1 || SETUP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ps2_host_tx: cycle parameters must be at least 1");
    end

    logic             clk_meta_q, clk_sync_q, clk_dly_q;
    logic             data_meta_q, data_sync_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       byte_q, byte_d;
    logic             clock_oe_q, clock_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             dev_fall;
    logic [9:0]       frame_bits;

    assign dev_fall   = clk_dly_q & ~clk_sync_q;
    // Index 9 is the stop bit, released high; index 8 is odd parity.
    assign frame_bits = {1'b1, ~^byte_q, byte_q};

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] timer_q, timer_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        clock_oe_d = clock_oe_q;
        data_oe_d  = data_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        timer_d    = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d    = INHIBIT;
                    byte_d     = tx_data;
                    busy_d     = 1'b1;
                    clock_oe_d = 1'b1;
                    data_oe_d  = 1'b0;
                    cnt_d      = '0;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d   = START;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START: begin
                if (cnt_q == SET_LAST) begin
                    state_d    = SEND;
                    clock_oe_d = 1'b0;
                    bit_d      = '0;
`ifdef PS2_TX_TIMEOUT_EN
                    timer_d    = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (dev_fall) begin
                    data_oe_d = ~frame_bits[bit_q];
                    if (bit_q == 4'd9) begin
                        state_d = ACK;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ACK: begin
                if (dev_fall) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    clock_oe_d = 1'b0;
                    data_oe_d  = 1'b0;
                    done_d     = ~data_sync_q;
                    error_d    = data_sync_q;
                end
            end
            default: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                clock_oe_d = 1'b0;
                data_oe_d  = 1'b0;
            end
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog wins over a same-cycle ack so done/error stay exclusive.
        if (state_q == SEND || state_q == ACK) begin
            timer_d = timer_q + 1'b1;
            if (timer_q == TMO_LAST) begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                clock_oe_d = 1'b0;
                data_oe_d  = 1'b0;
                done_d     = 1'b0;
                error_d    = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_dly_q   <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            clock_oe_q  <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            clk_meta_q  <= ps2_clock;
            clk_sync_q  <= clk_meta_q;
            clk_dly_q   <= clk_sync_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            clock_oe_q  <= clock_oe_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign ps2_clock_oe = clock_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign busy         = busy_q;
    assign tx_done      = done_q;
    assign tx_error     = error_q;

endmodule
